// File: rtl/alu_cmd_seq_if.sv
// Command and result handshake channels of the ALU command sequencer.
// The master side is the upstream/downstream agent, and the slave side is the sequencer.
interface alu_cmd_seq_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_num1;
    logic [W-1:0] cmd_num2;
    logic [5:0]   cmd_op;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;

    modport master (
        output cmd_valid, cmd_num1, cmd_num2, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_num1, cmd_num2, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues {num1, num2, op} commands and steps each one through an external ALU.
// Each legal command passes through LOAD and EXEC, then is held in DONE until the result is accepted.
module alu_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    alu_cmd_seq_if.slave       bus,
    output logic [2:0]         alu_in_sel,
    output logic [5:0]         alu_out_sel,
    output logic [W-1:0]       alu_num1,
    output logic [W-1:0]       alu_num2,
    input  logic [W-1:0]       alu_out,
    output logic [1:0]         state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_EXEC = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_mem_num1 [DEPTH];
    logic [W-1:0]   r_mem_num2 [DEPTH];
    logic [5:0]     r_mem_op   [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic [5:0]     r_op;
    logic [W-1:0]   r_num1;
    logic [W-1:0]   r_num2;
    logic [W-1:0]   r_res_data;
    logic           r_res_err;

    logic           w_ready;
    logic           w_push;
    logic           w_pop;
    logic           w_nempty;
    logic [5:0]     w_head_op;
    logic           w_head_legal;

    // Readiness comes from the registered count, so a pop in the same cycle cannot open a slot.
    assign w_ready      = !reset && !flush && (r_count != CW'(DEPTH));
    assign w_nempty     = (r_count != '0);
    assign w_push       = bus.cmd_valid && w_ready;
    assign w_pop        = (r_state == S_IDLE) && w_nempty && !flush;
    assign w_head_op    = r_mem_op[r_rd_ptr];
    assign w_head_legal = $onehot(w_head_op);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_num1[r_wr_ptr] <= bus.cmd_num1;
            r_mem_num2[r_wr_ptr] <= bus.cmd_num2;
            r_mem_op[r_wr_ptr]   <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_nempty) begin
                        w_state_nxt = w_head_legal ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: w_state_nxt = S_EXEC;
                S_EXEC: w_state_nxt = S_DONE;
                S_DONE: begin
                    if (bus.res_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operands are only loaded by legal commands, so the ALU inputs keep their last values otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_num1     <= '0;
            r_num2     <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else if (w_pop) begin
            r_op <= w_head_op;
            if (w_head_legal) begin
                r_num1 <= r_mem_num1[r_rd_ptr];
                r_num2 <= r_mem_num2[r_rd_ptr];
            end else begin
                r_res_data <= '0;
                r_res_err  <= 1'b1;
            end
        end else if ((r_state == S_EXEC) && !flush) begin
            r_res_data <= alu_out;
            r_res_err  <= 1'b0;
        end
    end

    always_comb begin
        alu_in_sel  = 3'b000;
        alu_out_sel = '0;
        unique case (r_state)
            S_LOAD: alu_in_sel = 3'b010;
            S_EXEC: begin
                alu_in_sel  = 3'b100;
                alu_out_sel = r_op;
            end
            default: ;
        endcase
        if (reset || flush) begin
            alu_in_sel = 3'b001;
        end
    end

    assign alu_num1      = r_num1;
    assign alu_num2      = r_num2;
    assign state         = r_state;
    assign bus.cmd_ready = w_ready;
    assign bus.res_valid = (r_state == S_DONE);
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a queue-based behavioural model checked on every negedge.
module tb_alu_cmd_seq;
    localparam int DEPTH = 4;
    localparam int W     = 8;

    typedef struct packed {
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        logic [5:0]   op;
    } cmd_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic [2:0]   alu_in_sel;
    logic [5:0]   alu_out_sel;
    logic [W-1:0] alu_num1;
    logic [W-1:0] alu_num2;
    logic [W-1:0] alu_out;
    logic [1:0]   state;

    int n_vec = 0;
    int n_bad = 0;

    alu_cmd_seq_if #(.W(W)) bus ();

    alu_cmd_seq #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus.slave),
        .alu_in_sel (alu_in_sel),
        .alu_out_sel(alu_out_sel),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_out    (alu_out),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [5:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            6'b000001: return a + b;
            6'b000010: return a - b;
            6'b000100: return a & b;
            6'b001000: return a | b;
            6'b010000: return a ^ b;
            6'b100000: return a << 1;
            default:   return '0;
        endcase
    endfunction

    // Stand-in ALU attached to the sequencer's ALU ports.
    assign alu_out = alu_ref(alu_out_sel, alu_num1, alu_num2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: pending queue, one in-flight command aged in cycles since its pop, and a held result.
    cmd_t         q[$];
    cmd_t         m_cur;
    bit           m_have  = 1'b0;
    bit           m_valid = 1'b0;
    int           m_age   = 0;
    logic [W-1:0] m_res   = '0;
    logic         m_err   = 1'b0;
    logic [W-1:0] m_last1 = '0;
    logic [W-1:0] m_last2 = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_have  = 1'b0;
            m_valid = 1'b0;
            m_age   = 0;
            m_res   = '0;
            m_err   = 1'b0;
            m_last1 = '0;
            m_last2 = '0;
        end else if (flush) begin
            q.delete();
            m_have  = 1'b0;
            m_valid = 1'b0;
        end else begin
            bit acc;
            acc = bus.cmd_valid && (q.size() != DEPTH);
            if (m_valid) begin
                if (bus.res_ready) begin
                    m_valid = 1'b0;
                    m_have  = 1'b0;
                end
            end else if (m_have) begin
                m_age++;
                if (m_age == 3) begin
                    m_valid = 1'b1;
                    m_res   = alu_ref(m_cur.op, m_cur.n1, m_cur.n2);
                    m_err   = 1'b0;
                end
            end else if (q.size() > 0) begin
                m_cur  = q.pop_front();
                m_have = 1'b1;
                m_age  = 1;
                if ($onehot(m_cur.op)) begin
                    m_last1 = m_cur.n1;
                    m_last2 = m_cur.n2;
                end else begin
                    m_valid = 1'b1;
                    m_res   = '0;
                    m_err   = 1'b1;
                end
            end
            if (acc) begin
                q.push_back({bus.cmd_num1, bus.cmd_num2, bus.cmd_op});
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] es;
        logic [2:0] eis;
        logic [5:0] eos;
        logic       erdy;
        es   = m_valid ? 2'd3 : (m_have ? ((m_age == 1) ? 2'd1 : 2'd2) : 2'd0);
        eis  = (reset || flush) ? 3'b001 : (es == 2'd1) ? 3'b010 : (es == 2'd2) ? 3'b100 : 3'b000;
        eos  = (es == 2'd2) ? m_cur.op : 6'd0;
        erdy = !reset && !flush && (q.size() != DEPTH);
        chk("state", 32'(state), 32'(es));
        chk("alu_in_sel", 32'(alu_in_sel), 32'(eis));
        chk("alu_out_sel", 32'(alu_out_sel), 32'(eos));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(erdy));
        chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
        chk("alu_num1", 32'(alu_num1), 32'(m_last1));
        chk("alu_num2", 32'(alu_num2), 32'(m_last2));
        if (m_valid) begin
            chk("res_data", 32'(bus.res_data), 32'(m_res));
            chk("res_err", 32'(bus.res_err), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_num1  = a;
        bus.cmd_num2  = b;
        bus.cmd_op    = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_num1  = '0;
        bus.cmd_num2  = '0;
        bus.cmd_op    = '0;
        bus.res_ready = 1'b1;
        #1;
        chk("rst_in_sel", 32'(alu_in_sel), 32'h1);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.cmd_ready), 32'h1);

        // Single add: 0x57 + 0x1A.
        set_cmd(8'h57, 8'h1A, 6'b000001);
        step();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t1_load_in_sel", 32'(alu_in_sel), 32'h2);
        @(negedge clk);
        chk("t1_exec_in_sel", 32'(alu_in_sel), 32'h4);
        @(negedge clk);
        chk("t1_res_valid", 32'(bus.res_valid), 32'h1);
        chk("t1_res_data", 32'(bus.res_data), 32'h71);
        chk("t1_res_err", 32'(bus.res_err), 32'h0);
        repeat (3) step();

        // Illegal op goes straight to DONE.
        set_cmd(8'h12, 8'h34, 6'b000011);
        step();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_state", 32'(state), 32'h3);
        chk("t2_res_err", 32'(bus.res_err), 32'h1);
        chk("t2_res_data", 32'(bus.res_data), 32'h0);
        chk("t2_in_sel", 32'(alu_in_sel), 32'h0);
        repeat (3) step();

        // Fill: 5 accepted, 6th blocked, then drain in order.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_cmd(8'(8'h10 * i + 3), 8'(i + 1), 6'(1 << i));
            step();
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_full_ready", 32'(bus.cmd_ready), 32'h0);
        chk("t3_state", 32'(state), 32'h3);
        bus.res_ready = 1'b1;
        repeat (25) step();

        // Backpressure in DONE for 10 cycles.
        bus.res_ready = 1'b0;
        set_cmd(8'hF0, 8'h3C, 6'b010000);
        step();
        set_cmd(8'h05, 8'h07, 6'b000010);
        step();
        bus.cmd_valid = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_state", 32'(state), 32'h3);
            chk("t4_hold_data", 32'(bus.res_data), 32'hCC);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle", 32'(state), 32'h0);
        @(negedge clk);
        chk("t4_next_load", 32'(state), 32'h1);
        repeat (6) step();

        // Flush in EXEC with two queued and a same-cycle command.
        set_cmd(8'h21, 8'h02, 6'b000001);
        step();
        set_cmd(8'h22, 8'h03, 6'b000100);
        step();
        set_cmd(8'h23, 8'h04, 6'b001000);
        step();
        flush = 1'b1;
        set_cmd(8'h24, 8'h05, 6'b000001);
        @(negedge clk);
        chk("t5_flush_in_sel", 32'(alu_in_sel), 32'h1);
        chk("t5_exec_state", 32'(state), 32'h2);
        step();
        flush = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_state", 32'(state), 32'h0);
        chk("t5_ready", 32'(bus.cmd_ready), 32'h1);
        chk("t5_res_valid", 32'(bus.res_valid), 32'h0);
        repeat (8) step();

        // Async reset mid-LOAD with one pending command.
        set_cmd(8'h44, 8'h11, 6'b000010);
        step();
        set_cmd(8'h55, 8'h66, 6'b000001);
        step();
        bus.cmd_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("t6_state", 32'(state), 32'h0);
        chk("t6_in_sel", 32'(alu_in_sel), 32'h1);
        chk("t6_ready", 32'(bus.cmd_ready), 32'h0);
        chk("t6_res_valid", 32'(bus.res_valid), 32'h0);
        chk("t6_num1", 32'(alu_num1), 32'h0);
        chk("t6_num2", 32'(alu_num2), 32'h0);
        chk("t6_out_sel", 32'(alu_out_sel), 32'h0);
        chk("t6_res_data", 32'(bus.res_data), 32'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4, sets command FIFO depth (power of 2, at least 2).
REQ-002 Parameter W, default 8, sets operand and result width.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: synchronous abort of all pending and in-flight work.
REQ-006 Port cmd_valid, input, 1 bit: upstream command present.
REQ-007 Port cmd_ready, output, 1 bit: sequencer can accept a command.
REQ-008 Port cmd_num1, input, W bits: first operand.
REQ-009 Port cmd_num2, input, W bits: second operand.
REQ-010 Port cmd_op, input, 6 bits: one-hot ALU operation select.
REQ-011 Port alu_in_sel, output, 3 bits: ALU input control; bit2 = persist, bit1 = load, bit0 = reset.
REQ-012 Port alu_out_sel, output, 6 bits: ALU operation select.
REQ-013 Ports alu_num1 and alu_num2, output, W bits each: operands driven to the ALU.
REQ-014 Port alu_out, input, W bits: ALU result.
REQ-015 Port res_valid, output, 1 bit: result available.
REQ-016 Port res_ready, input, 1 bit: downstream accepts the result.
REQ-017 Port res_data, output, W bits: captured result.
REQ-018 Port res_err, output, 1 bit: the command carried an illegal op.
REQ-019 Port state, output, 2 bits: current FSM state.

Function
REQ-020 The FIFO shall hold DEPTH entries of {num1, num2, op}, track an occupancy count of 0..DEPTH, and wrap its pointers modulo DEPTH.
REQ-021 cmd_ready shall equal (count != DEPTH) and not flush, computed from registered count; a push occurs on (cmd_valid and cmd_ready), and no push occurs when full even if a pop happens in the same cycle.
REQ-022 The FSM shall have four states: IDLE = 00, LOAD = 01, EXEC = 10, DONE = 11.
REQ-023 In IDLE with count > 0, the sequencer shall pop the head into the operation registers; a one-hot op moves to LOAD, and a non-one-hot op (including zero) moves to DONE with res_data = 0 and res_err = 1.
REQ-024 In IDLE with count = 0, the FSM shall stay in IDLE.
REQ-025 LOAD shall drive alu_in_sel = 010, alu_out_sel = 000000, and alu_num1/alu_num2 from the operation registers, then go to EXEC unconditionally.
REQ-026 EXEC shall drive alu_in_sel = 100 and alu_out_sel = the registered op, keep the operands driven, capture alu_out into res_data with res_err = 0 at the closing edge, and go to DONE.
REQ-027 DONE shall assert res_valid with res_data/res_err held stable, and shall move to IDLE on res_ready; no pop occurs in the DONE-to-IDLE cycle.
REQ-028 IDLE and DONE shall drive alu_in_sel = 000 and alu_out_sel = 000000; alu_num1/alu_num2 hold their last values.
REQ-029 A push into an empty FIFO in IDLE at edge E0 shall produce res_valid high after edge E0+3 for a legal op.
REQ-030 Throughput shall be one command per 4 cycles when res_ready is held high.
REQ-031 While flush = 1, alu_in_sel shall be 001 combinationally, overriding the state decode.
REQ-032 At the edge where flush = 1, count and pointers shall clear, state shall go to IDLE, res_valid shall drop, and a same-cycle command shall be dropped.
REQ-033 Flush shall take priority over push, pop, and res_ready.
REQ-034 Pushes during LOAD/EXEC/DONE shall be accepted into the FIFO and not disturb the operation in flight.

Reset
REQ-035 While reset = 1, the sequencer shall asynchronously force: state = IDLE, count = 0, pointers = 0, res_valid = 0, res_data = 0, res_err = 0, alu_num1 = 0, alu_num2 = 0, alu_out_sel = 000000, alu_in_sel = 001, cmd_ready = 0.
REQ-036 After reset deasserts, cmd_ready shall be 1 in the first cycle.
REQ-037 Reset mid-operation shall discard all pending and in-flight commands with no result emitted.

Verification
REQ-038 Single command: push num1 = 0x57, num2 = 0x1A, op = 000001 with a bench ALU model that adds -> in_sel sequence 010, 100, res_data = 0x71, res_err = 0, res_valid 3 edges after the push.
REQ-039 Illegal op: push op = 000011 -> no LOAD/EXEC cycles, res_valid with res_data = 0x00 and res_err = 1.
REQ-040 Full: res_ready = 0, push 5 commands back-to-back -> 1 in flight, FIFO fills to 4, cmd_ready = 0, the next push is blocked; the results later emerge in push order.
REQ-041 Backpressure: hold res_ready = 0 for 10 cycles in DONE -> res_data stable, state = 11; after release, IDLE, then the next pop.
REQ-042 Flush in EXEC with 2 entries queued -> alu_in_sel = 001 for that cycle, then state = 00, count = 0, res_valid = 0.
REQ-043 Async reset asserted mid-LOAD, between clock edges -> outputs reach reset values immediately, with no result afterwards.
